// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Bursts of up to BURST_LEN words per grant; stalls while wfull; one idle bubble between grants.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATASIZE  = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATASIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATASIZE-1:0]           wdata,
  output logic                          busy,
  output logic [2:0]                    grant_id,
  output logic [15:0]                   wr_count
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q;
  logic [2:0]    grant_q, grant_d;
  logic [3:0]    burst_q;
  logic [15:0]   cnt_q, cnt_d;
  logic [IW-1:0] g;
  logic          any_req;

  logic [DATASIZE-1:0] data_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign data_a[i] = req_data[i*DATASIZE +: DATASIZE];
  end

  assign g       = grant_q[IW-1:0];
  assign any_req = |req;
  assign busy    = (state_q == GRANT);
  assign winc    = busy & req[g] & ~wfull;
  assign ack     = winc ? (NUM_REQ'(1) << g) : '0;
  assign wdata   = busy ? data_a[g] : '0;
  assign grant_id = grant_q;
  assign wr_count = cnt_q;

  // First requesting index above the last grant, wrapping.
  always_comb begin
    int  idx;
    logic found;
    grant_d = grant_q;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(grant_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        grant_d = 3'(idx);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (winc && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state_q <= IDLE;
      grant_q <= 3'(NUM_REQ-1);
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= grant_d;
            burst_q <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!req[g]) begin
            state_q <= IDLE;
          end else if (winc) begin
            burst_q <= burst_q + 4'd1;
            if (burst_q == 4'(BURST_LEN-1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the write port of the async FIFO (winc/wdata/wfull, write-clock domain) between NUM_REQ requesters.
- Grants one requester at a time for a burst of at most BURST_LEN words, and stalls on wfull.
- Sits entirely in the wclk domain, in front of the FIFO write interface; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATASIZE, 8, data word width; matches the FIFO DATASIZE.
- BURST_LEN, 4, maximum words accepted per grant (1..15).

Ports:
- wclk  input  1  write-domain clock; all state on rising edge.
- wrst  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester write request; held while the requester has a word.
- req_data  input  NUM_REQ*DATASIZE  requester i's word at [i*DATASIZE +: DATASIZE].
- ack  output  NUM_REQ  one-hot; ack[i]=1 means req_data[i] is written this cycle.
- wfull  input  1  FIFO full flag.
- winc  output  1  FIFO write enable.
- wdata  output  DATASIZE  FIFO write data.
- busy  output  1  arbiter in GRANT state.
- grant_id  output  3  index of the current or last granted requester.
- wr_count  output  16  total words written since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (wrst=0, async):
  - state=IDLE, grant_id=NUM_REQ-1, so requester 0 wins first.
  - burst counter=0, wr_count=0.
  - Outputs: winc=0, ack=0, wdata=0, busy=0.
- IDLE state:
  - If any req bit is set, select the first set bit scanning from grant_id+1 upward, wrapping modulo NUM_REQ.
  - Register it into grant_id, clear the burst counter, move to GRANT.
  - No write occurs in IDLE.
- GRANT state (g=grant_id):
  - Combinationally: winc = req[g] & ~wfull; ack = winc ? (1<<g) : 0.
  - wdata = req_data[g] while in GRANT, else 0.
  - On each edge with winc=1: burst counter +1, wr_count +1 (saturating).
- Leaving GRANT:
  - Go to IDLE when req[g]=0, or when winc=1 and the burst counter reaches BURST_LEN-1 (the BURST_LEN-th word).
  - IDLE always costs one bubble cycle before the next grant.
- wfull:
  - While wfull=1 in GRANT: no write, no ack, the burst counter is frozen, state is held.
  - No timeout; a stalled requester keeps its grant until the FIFO drains.
- Request withdrawal: if req[g] drops during GRANT, that cycle does no write and the next state is IDLE. This is legal even mid-burst.
- Latency: req rising in IDLE gives the first winc/ack in the next cycle, assuming wfull=0.
- Fairness:
  - After a grant to g, priority rotates to g+1.
  - With all requesters active, grants cycle 0,1,..,NUM_REQ-1,0,...
  - A sole active requester is re-granted after each one-cycle bubble.
- Requests to non-granted requesters are ignored; their ack stays 0 and no data is lost because they hold req.
- Never assert winc while wfull=1. ack is always one-hot or zero.
- Reset mid-burst: state returns to IDLE immediately and outputs clear. Any partial burst is abandoned; words already written stay in the FIFO.

Test Plan:
- Reset then req=4'b0001, data0=8'hA0..A3 changing per ack, wfull=0 -> cycle 1 onward: winc=1 for 4 cycles with wdata A0,A1,A2,A3; ack=0001; then 1 IDLE cycle; wr_count=4.
- req=4'b1111 held, BURST_LEN=4, wfull=0 -> grant order 0,1,2,3,0; each burst is 4 words plus a 1-cycle bubble; wr_count=16 after 4 bursts (20 cycles).
- Requester 2 granted, wfull raised after its 2nd word for 5 cycles -> winc=0 and ack=0 for those 5 cycles, grant held; words 3 and 4 then written; burst total is exactly 4.
- Requester 1 drops req after 1 word -> next cycle winc=0, state IDLE; the next grant goes to the next active index above 1.
- wrst asserted mid-burst (word 2 of 4) -> same cycle: winc=0, ack=0, busy=0, wr_count=0; after release, req 0 is served first.
- 70000 writes with wfull=0 -> wr_count=16'hFFFF and holds.
